// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter for the single-port data memory.
//   Port 0 (m0_*) : CPU load/store path.
//   Port 1 (m1_*) : loader/debug DMA path. m1_lock holds the grant for bursts.
//                   The burst is force-released after MAX_BURST beats while
//                   port 0 is waiting.
//   Memory (mem_*): combinational request drive. Read data arrives one cycle
//                   after the strobe and is routed back to the issuing port.
// Reset is asynchronous and active-high.
module dmem_arbiter #(
    parameter int ADDR_W    = 9,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    // port 0: CPU
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_be,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    output logic [31:0]       m0_rdata,
    // port 1: loader / debug DMA
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_be,
    input  logic              m1_lock,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [31:0]       m1_rdata,
    // memory side
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             r_last_winner;  // 1 = port 1 won the last accepted beat
    logic             r_locked;
    logic [CNT_W-1:0] r_burst_cnt;
    logic             r_rd_tag_valid;
    logic             r_rd_tag;       // port that issued the in-flight read
    logic [31:0]      r_m0_rdata;
    logic [31:0]      r_m1_rdata;

    logic w_g0, w_g1, w_at_cap, w_force_rel;

    // Grant selection. Grants are masked during reset so every output is
    // quiet while rst is high, regardless of the request inputs.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        if (!rst) begin
            if (r_locked && m1_req) begin
                w_g1 = 1'b1;
            end else if (m0_req && m1_req) begin
                w_g0 = r_last_winner;
                w_g1 = !r_last_winner;
            end else begin
                w_g0 = m0_req;
                w_g1 = m1_req;
            end
        end
    end

    assign m0_gnt = w_g0;
    assign m1_gnt = w_g1;

    always_comb begin
        mem_en    = w_g0 | w_g1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (w_g0) begin
            mem_we    = m0_we;
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_be    = m0_be;
        end else if (w_g1) begin
            mem_we    = m1_we;
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_be    = m1_be;
        end
    end

    // The cap only bites while port 0 is waiting; otherwise the counter
    // just saturates and the burst runs on.
    assign w_at_cap    = (r_burst_cnt == CNT_W'(MAX_BURST - 1));
    assign w_force_rel = w_g1 && m1_lock && m0_req && w_at_cap;

    // Read data is passed straight through in the return cycle. Each port
    // keeps its last returned word, so its rdata holds while the other
    // port is being served.
    assign m0_rvalid = r_rd_tag_valid && !r_rd_tag;
    assign m1_rvalid = r_rd_tag_valid &&  r_rd_tag;
    assign m0_rdata  = m0_rvalid ? mem_rdata : r_m0_rdata;
    assign m1_rdata  = m1_rvalid ? mem_rdata : r_m1_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_winner  <= 1'b1;
            r_locked       <= 1'b0;
            r_burst_cnt    <= '0;
            r_rd_tag_valid <= 1'b0;
            r_rd_tag       <= 1'b0;
            r_m0_rdata     <= '0;
            r_m1_rdata     <= '0;
        end else begin
            if (w_g0 || w_g1) begin
                r_last_winner  <= w_g1;
                r_rd_tag_valid <= !mem_we;
                r_rd_tag       <= w_g1;
            end else begin
                r_rd_tag_valid <= 1'b0;
            end

            r_locked <= w_g1 && m1_lock && !(m0_req && w_at_cap);

            if (w_g0 || !w_g1 || w_force_rel) begin
                r_burst_cnt <= '0;
            end else if (r_locked || m1_lock) begin
                if (!w_at_cap) r_burst_cnt <= r_burst_cnt + 1'b1;
            end else begin
                r_burst_cnt <= '0;
            end

            if (m0_rvalid) r_m0_rdata <= mem_rdata;
            if (m1_rvalid) r_m1_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W = 9;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m0_we, m0_gnt, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [31:0]       m0_wdata, m0_rdata;
    logic [3:0]        m0_be;
    logic              m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [31:0]       m1_wdata, m1_rdata;
    logic [3:0]        m1_be;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [128];

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_be(m0_be), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_be(m1_be), .m1_lock(m1_lock), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid),
        .m1_rdata(m1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    // Word-organised memory with byte enables and a 1-cycle read.
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr[8:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= mem[mem_addr[8:2]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_be = 4'hF;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_be = 4'hF; m1_lock = 0;
    endtask

    initial begin
        int beats;
        int cyc;
        logic got;

        for (int i = 0; i < 128; i++) mem[i] = 32'h0;
        mem[1] = 32'h1111_1111;   // 0x04
        mem[2] = 32'h2222_2222;   // 0x08
        mem[3] = 32'h3333_3333;   // 0x0C
        mem[4] = 32'hDEAD_BEEF;   // 0x10
        mem_rdata = '0;
        idle();

        // reset state, with a request held so grant masking is exercised
        rst = 1;
        m0_req = 1; m0_addr = 9'h10;
        #2;
        chk("rst_m0_gnt", 32'(m0_gnt), 0);
        chk("rst_mem_en", 32'(mem_en), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
        chk("rst_m0_rdata", m0_rdata, 0);
        repeat (2) @(posedge clk);
        #1; rst = 0; idle();

        // single m0 read
        m0_req = 1; m0_addr = 9'h10;
        #1;
        chk("rd0_m0_gnt", 32'(m0_gnt), 1);
        chk("rd0_m1_gnt", 32'(m1_gnt), 0);
        chk("rd0_mem_en", 32'(mem_en), 1);
        chk("rd0_mem_addr", 32'(mem_addr), 32'h10);
        tick(); idle(); #1;
        chk("rd0_m0_rvalid", 32'(m0_rvalid), 1);
        chk("rd0_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("rd0_m1_rvalid", 32'(m1_rvalid), 0);
        tick();

        // round robin from reset state
        rst = 1; #1; rst = 0;
        m0_req = 1; m0_addr = 9'h20;
        m1_req = 1; m1_addr = 9'h40;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk($sformatf("rr%0d_m0_gnt", i), 32'(m0_gnt), 32'(i % 2 == 0));
            chk($sformatf("rr%0d_m1_gnt", i), 32'(m1_gnt), 32'(i % 2 == 1));
            chk($sformatf("rr%0d_addr", i), 32'(mem_addr), (i % 2 == 0) ? 32'h20 : 32'h40);
            tick();
        end
        idle(); tick();

        // unlimited locked burst while m0 is idle
        m1_req = 1; m1_we = 1; m1_lock = 1;
        for (int i = 0; i < 16; i++) begin
            m1_addr  = ADDR_W'(9'h100 + 4 * i);
            m1_wdata = 32'hA000_0000 + 32'(i);
            #1;
            chk($sformatf("burst%0d_m1_gnt", i), 32'(m1_gnt), 1);
            tick();
        end
        idle();
        m0_req = 1; m0_addr = 9'h100;
        #1;
        chk("burst_rd_gnt", 32'(m0_gnt), 1);
        tick(); idle(); #1;
        chk("burst_rd_data", m0_rdata, 32'hA000_0000);
        tick();

        // forced release: m0 raises req on the 2nd beat of a locked burst
        m1_req = 1; m1_we = 1; m1_lock = 1; m1_addr = 9'h180; m1_wdata = 32'h5A5A_5A5A;
        m0_addr = 9'h104;
        beats = 0; got = 0; cyc = 0;
        for (int c = 0; c < 12; c++) begin
            cyc = c;
            if (c == 1) m0_req = 1;
            #1;
            if (m0_gnt) begin
                got = 1;
                break;
            end
            if (m1_gnt) beats++;
            tick();
        end
        chk("cap_m0_granted", 32'(got), 1);
        chk("cap_m1_beats", 32'(beats), 8);
        chk("cap_wait_le9", 32'(cyc <= 9), 1);
        tick(); idle(); #1;
        chk("cap_m0_rdata", m0_rdata, 32'hA000_0001);
        tick();

        // alternating reads return in order to the right port
        m0_req = 1; m0_addr = 9'h04;
        #1;
        chk("alt_m0_gnt", 32'(m0_gnt), 1);
        tick(); idle();
        m1_req = 1; m1_addr = 9'h08;
        #1;
        chk("alt_m1_gnt", 32'(m1_gnt), 1);
        chk("alt1_m0_rvalid", 32'(m0_rvalid), 1);
        chk("alt1_m0_rdata", m0_rdata, 32'h1111_1111);
        tick(); idle();
        m0_req = 1; m0_addr = 9'h0C;
        #1;
        chk("alt2_m1_rvalid", 32'(m1_rvalid), 1);
        chk("alt2_m1_rdata", m1_rdata, 32'h2222_2222);
        chk("alt2_m0_rvalid", 32'(m0_rvalid), 0);
        chk("alt2_m0_hold", m0_rdata, 32'h1111_1111);
        tick(); idle(); #1;
        chk("alt3_m0_rvalid", 32'(m0_rvalid), 1);
        chk("alt3_m0_rdata", m0_rdata, 32'h3333_3333);
        chk("alt3_m1_rvalid", 32'(m1_rvalid), 0);
        chk("alt3_m1_hold", m1_rdata, 32'h2222_2222);
        tick();

        // read/write conflict: m0 won last, so m1 read goes first
        m0_req = 1; m0_we = 1; m0_addr = 9'h0C; m0_wdata = 32'h5555_5555; m0_be = 4'b0011;
        m1_req = 1; m1_we = 0; m1_addr = 9'h0C;
        #1;
        chk("cf_m1_gnt", 32'(m1_gnt), 1);
        chk("cf_m0_gnt", 32'(m0_gnt), 0);
        chk("cf_mem_we0", 32'(mem_we), 0);
        tick();
        m1_req = 0;
        #1;
        chk("cf_m0_gnt2", 32'(m0_gnt), 1);
        chk("cf_mem_we1", 32'(mem_we), 1);
        chk("cf_mem_be", 32'(mem_be), 32'h3);
        chk("cf_mem_wdata", mem_wdata, 32'h5555_5555);
        chk("cf_m1_rvalid", 32'(m1_rvalid), 1);
        chk("cf_m1_rdata", m1_rdata, 32'h3333_3333);
        tick(); idle();
        m0_req = 1; m0_addr = 9'h0C;
        #1;
        chk("cf_rd_gnt", 32'(m0_gnt), 1);
        tick(); idle(); #1;
        chk("cf_rd_data", m0_rdata, 32'h3333_5555);
        tick();

        // reset with an m1 read in flight
        m1_req = 1; m1_addr = 9'h08;
        #1;
        chk("rr_m1_gnt", 32'(m1_gnt), 1);
        @(posedge clk);
        #1; rst = 1;
        #1;
        chk("rr_m1_rvalid", 32'(m1_rvalid), 0);
        chk("rr_m1_rdata", m1_rdata, 0);
        chk("rr_m0_rdata", m0_rdata, 0);
        chk("rr_m1_gnt_rst", 32'(m1_gnt), 0);
        chk("rr_mem_en", 32'(mem_en), 0);
        @(posedge clk);
        #1; rst = 0;
        m0_req = 1; m0_addr = 9'h04;
        #1;
        chk("rr_first_m0_gnt", 32'(m0_gnt), 1);
        chk("rr_first_m1_gnt", 32'(m1_gnt), 0);
        tick(); idle(); #1;
        chk("rr_m0_rdata_after", m0_rdata, 32'h1111_1111);
        chk("rr_m1_rvalid_after", 32'(m1_rvalid), 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #50000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters. Port 0 is the CPU load/store path; port 1 is the loader/debug DMA path used to preload and inspect data memory.
- Uses round-robin arbitration. Port 1 may lock the grant for bursts, capped at MAX_BURST beats.
- Memory reads have a fixed 1-cycle latency. The arbiter tags each read and returns data only to the port that issued it.
- Sits between the core's data memory interface and the data memory.

Parameters:
- ADDR_W, 9, byte-address width presented to the memory (512-byte data memory).
- MAX_BURST, 8, maximum consecutive locked beats granted to port 1 while port 0 is requesting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m0_req  in  1  CPU access request.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  CPU byte address.
- m0_wdata  in  32  CPU write data.
- m0_be  in  4  CPU byte enables.
- m0_gnt  out  1  CPU request accepted this cycle; low means the CPU stalls.
- m0_rvalid  out  1  CPU read data valid.
- m0_rdata  out  32  CPU read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_be, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for port 1.
- m1_lock  in  1  asks to keep the grant on the next cycle (burst).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_be  out  4  memory byte enables.
- mem_rdata  in  32  memory read data, valid 1 cycle after a read strobe.

Behaviour:
- Reset (async, immediate):
  - m0_gnt, m1_gnt, m0_rvalid, m1_rvalid = 0; m0_rdata, m1_rdata = 0.
  - mem_en, mem_we = 0; mem_addr, mem_wdata, mem_be = 0.
  - last_winner = 1, so port 0 wins the first tie.
  - burst_cnt = 0; locked = 0; rd_tag_valid = 0.
- Grant logic (combinational from current requests and registered state):
  - Exactly one or zero gnt high per cycle. A transaction is accepted when req && gnt.
  - If locked = 1 and m1_req = 1: grant port 1.
  - Otherwise, if only one port requests: grant it.
  - Otherwise, if both request: grant the port that is not last_winner.
  - No request: both gnt = 0, mem_en = 0.
- Memory drive:
  - mem_en = m0_gnt | m1_gnt.
  - mem_we, mem_addr, mem_wdata, mem_be mux from the granted port.
  - With no grant, they hold 0.
- Registered updates on each accepted beat:
  - last_winner <= granted port.
  - rd_tag_valid <= !we; rd_tag <= granted port.
- Read return:
  - The cycle after an accepted read, mX_rvalid = 1 for the tagged port only, and mX_rdata = mem_rdata.
  - The other port's rvalid = 0 and its rdata holds its previous value.
  - Writes produce no rvalid.
  - Back-to-back reads from alternating ports return in issue order, one per cycle.
- Lock / burst:
  - locked <= m1_gnt && m1_lock && !(m0_req && burst_cnt == MAX_BURST-1).
  - burst_cnt increments on each m1 beat while locked or m1_lock.
  - burst_cnt clears to 0 on any m0 grant, on a cycle with no m1 beat, or when the lock is force-released.
  - The forced release guarantees port 0 a grant within MAX_BURST+1 cycles of asserting m0_req.
  - If m0_req is low, the burst is unlimited (burst_cnt saturates at MAX_BURST-1).
  - m1_lock with m1_req low drops the lock.
- Boundary conditions:
  - Simultaneous read on one port and write on the other: only one is granted. The loser holds its req, is granted next cycle, and the arbiter does not reorder its data.
  - Address wraps modulo 2^ADDR_W (no range check).
  - Reset asserted mid-burst or with a read in flight: the pending rvalid is dropped and the lock is cleared. After release, arbitration restarts from the reset state.

Test Plan:
- Only m0 reads addr 0x10 (mem holds 0xDEADBEEF) -> m0_gnt=1 same cycle, mem_en=1, mem_addr=0x10; next cycle m0_rvalid=1, m0_rdata=0xDEADBEEF, m1_rvalid=0.
- m0 and m1 both hold req for 4 cycles starting from reset -> grants alternate m0,m1,m0,m1; mem_addr follows the winner.
- m1 burst-writes 0x100..0x13C with m1_lock=1 and m0_req=0 -> 16 consecutive m1 grants; then m0 reads 0x100 -> returns the first burst word.
- m1 locked burst with m0_req held from the burst's 2nd cycle, MAX_BURST=8 -> m0_gnt within at most 9 cycles; the m1 beat count before it is exactly 8.
- Alternating reads m0@0x04, m1@0x08, m0@0x0C -> rvalid pulses on m0, m1, m0 in consecutive cycles with the correct data each.
- rst pulsed one cycle after an m1 read is accepted -> m1_rvalid stays 0, all outputs 0 during reset; next simultaneous request grants m0 first.
